// File: rtl/reg_file_cc_if.sv
// reg_file_cc_if: read, write-back and branch-condition signals of the register file
interface reg_file_cc_if #(parameter int WIDTH = 16, parameter int AW = 3);
  logic [AW-1:0]    sr1;
  logic [AW-1:0]    sr2;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             wb_valid;
  logic [AW-1:0]    wb_dr;
  logic [WIDTH-1:0] wb_data;
  logic             wb_ld_cc;
  logic [2:0]       br_mask;
  logic             br_taken;
  logic [2:0]       nzp;
  logic             wb_busy;
  modport slave (
    input  sr1, sr2, wb_valid, wb_dr, wb_data, wb_ld_cc, br_mask,
    output ra, rb, br_taken, nzp, wb_busy
  );
  modport master (
    output sr1, sr2, wb_valid, wb_dr, wb_data, wb_ld_cc, br_mask,
    input  ra, rb, br_taken, nzp, wb_busy
  );
endinterface

// File: rtl/reg_file_cc.sv
// reg_file_cc: 8x16 register file with one-deep forwarded write-back stage and NZP branch evaluation
module reg_file_cc #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_cc_if.slave bus
);
  logic [WIDTH-1:0] regs [2**AW];
  logic             p_valid;
  logic [AW-1:0]    p_dr;
  logic [WIDTH-1:0] p_data;
  logic             p_cc;
  logic [2:0]       nzp_q;
  function automatic logic [2:0] cc(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? 3'b100 : (x == '0) ? 3'b010 : 3'b001;
  endfunction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) regs[i] <= '0;
      p_valid <= 1'b0;
      nzp_q   <= 3'b010;
    end else begin
      if (p_valid) begin
        regs[p_dr] <= p_data;
        if (p_cc) nzp_q <= cc(p_data);
      end
      p_valid <= bus.wb_valid;
      if (bus.wb_valid) begin
        p_dr   <= bus.wb_dr;
        p_data <= bus.wb_data;
        p_cc   <= bus.wb_ld_cc;
      end
    end
  end
  // pending entry shadows the array so a result is readable the cycle after it is presented
  always_comb begin
    bus.ra       = (p_valid && p_dr == bus.sr1) ? p_data : regs[bus.sr1];
    bus.rb       = (p_valid && p_dr == bus.sr2) ? p_data : regs[bus.sr2];
    bus.nzp      = nzp_q;
    bus.br_taken = |(bus.br_mask & nzp_q);
    bus.wb_busy  = p_valid;
  end
endmodule

// File: tb/tb_reg_file_cc.sv
// tb_reg_file_cc: directed scenarios plus randomized streams against a behavioural register-file model
module tb_reg_file_cc;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  reg_file_cc_if #(.WIDTH(16), .AW(3)) bus ();
  reg_file_cc #(.WIDTH(16), .AW(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [15:0] m_regs [8];
  logic [2:0]  m_nzp;
  logic        m_pv;
  logic [2:0]  m_pdr;
  logic [15:0] m_pdata;
  logic        m_pcc;
  function automatic logic [2:0] cc_of(input logic [15:0] x);
    if (x[15]) return 3'b100;
    if (x == 16'd0) return 3'b010;
    return 3'b001;
  endfunction
  function automatic logic [15:0] m_read(input logic [2:0] a);
    return (m_pv && m_pdr == a) ? m_pdata : m_regs[a];
  endfunction
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      foreach (m_regs[i]) m_regs[i] = 16'd0;
      m_pv  = 1'b0;
      m_nzp = 3'b010;
    end else begin
      if (m_pv) begin
        m_regs[m_pdr] = m_pdata;
        if (m_pcc) m_nzp = cc_of(m_pdata);
      end
      m_pv = bus.wb_valid;
      if (bus.wb_valid) begin
        m_pdr   = bus.wb_dr;
        m_pdata = bus.wb_data;
        m_pcc   = bus.wb_ld_cc;
      end
    end
    #1;
  endtask
  task automatic wb(input logic v, input logic [2:0] dr, input logic [15:0] d, input logic c);
    bus.wb_valid = v;
    bus.wb_dr    = dr;
    bus.wb_data  = d;
    bus.wb_ld_cc = c;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    wb(1'b0, 3'd0, 16'd0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.sr1 = 3'(i);
      bus.sr2 = 3'(7 - i);
      #1;
      vectors += 2;
      if (bus.ra !== 16'd0) begin miscompares++; $display("FAIL reset_ra[%0d] got %h want 0000", i, bus.ra); end
      if (bus.rb !== 16'd0) begin miscompares++; $display("FAIL reset_rb[%0d] got %h want 0000", 7 - i, bus.rb); end
    end
    vectors += 2;
    if (bus.nzp !== 3'b010) begin miscompares++; $display("FAIL reset_nzp got %b want 010", bus.nzp); end
    if (bus.wb_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.wb_busy); end
    bus.br_mask = 3'b010;
    #1;
    vectors++;
    if (bus.br_taken !== 1'b1) begin miscompares++; $display("FAIL reset_br010 got %b want 1", bus.br_taken); end
    bus.br_mask = 3'b101;
    #1;
    vectors++;
    if (bus.br_taken !== 1'b0) begin miscompares++; $display("FAIL reset_br101 got %b want 0", bus.br_taken); end
  endtask
  task automatic test_forward();
    wb(1'b1, 3'd3, 16'h1234, 1'b1);
    tick();
    wb(1'b0, 3'd0, 16'd0, 1'b0);
    bus.sr1 = 3'd3;
    #1;
    vectors += 2;
    if (bus.ra !== 16'h1234) begin miscompares++; $display("FAIL fwd_ra got %h want 1234", bus.ra); end
    if (bus.wb_busy !== 1'b1) begin miscompares++; $display("FAIL fwd_busy got %b want 1", bus.wb_busy); end
    tick();
    vectors += 3;
    if (bus.ra !== 16'h1234) begin miscompares++; $display("FAIL commit_ra got %h want 1234", bus.ra); end
    if (bus.nzp !== 3'b001) begin miscompares++; $display("FAIL commit_nzp got %b want 001", bus.nzp); end
    if (bus.wb_busy !== 1'b0) begin miscompares++; $display("FAIL commit_busy got %b want 0", bus.wb_busy); end
  endtask
  task automatic test_back_to_back();
    bus.sr2 = 3'd5;
    wb(1'b1, 3'd5, 16'h8000, 1'b1);
    tick();
    vectors++;
    if (bus.rb !== 16'h8000) begin miscompares++; $display("FAIL b2b_rb0 got %h want 8000", bus.rb); end
    wb(1'b1, 3'd5, 16'h0007, 1'b1);
    tick();
    wb(1'b0, 3'd0, 16'd0, 1'b0);
    #1;
    vectors += 2;
    if (bus.nzp !== 3'b100) begin miscompares++; $display("FAIL b2b_nzp1 got %b want 100", bus.nzp); end
    if (bus.rb !== 16'h0007) begin miscompares++; $display("FAIL b2b_rb1 got %h want 0007", bus.rb); end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors += 2;
      if (bus.nzp !== 3'b001) begin miscompares++; $display("FAIL b2b_nzp2[%0d] got %b want 001", i, bus.nzp); end
      if (bus.rb !== 16'h0007) begin miscompares++; $display("FAIL b2b_rb2[%0d] got %h want 0007", i, bus.rb); end
    end
  endtask
  task automatic test_no_cc();
    bus.sr1 = 3'd1;
    wb(1'b1, 3'd1, 16'd0, 1'b0);
    tick();
    wb(1'b0, 3'd0, 16'd0, 1'b0);
    tick();
    vectors += 2;
    if (bus.nzp !== 3'b001) begin miscompares++; $display("FAIL nocc_nzp got %b want 001", bus.nzp); end
    if (bus.ra !== 16'd0) begin miscompares++; $display("FAIL nocc_ra got %h want 0000", bus.ra); end
    wb(1'b1, 3'd1, 16'd0, 1'b1);
    tick();
    wb(1'b0, 3'd0, 16'd0, 1'b0);
    vectors++;
    if (bus.nzp !== 3'b001) begin miscompares++; $display("FAIL cc_not_fwd got %b want 001", bus.nzp); end
    tick();
    bus.br_mask = 3'b010;
    #1;
    vectors += 2;
    if (bus.nzp !== 3'b010) begin miscompares++; $display("FAIL cc_zero_nzp got %b want 010", bus.nzp); end
    if (bus.br_taken !== 1'b1) begin miscompares++; $display("FAIL cc_zero_br got %b want 1", bus.br_taken); end
  endtask
  task automatic test_reset_pending();
    bus.sr1 = 3'd2;
    wb(1'b1, 3'd2, 16'hFFFF, 1'b1);
    tick();
    wb(1'b0, 3'd0, 16'd0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    vectors += 3;
    if (bus.ra !== 16'd0) begin miscompares++; $display("FAIL rstp_ra got %h want 0000", bus.ra); end
    if (bus.nzp !== 3'b010) begin miscompares++; $display("FAIL rstp_nzp got %b want 010", bus.nzp); end
    if (bus.wb_busy !== 1'b0) begin miscompares++; $display("FAIL rstp_busy got %b want 0", bus.wb_busy); end
    tick();
    vectors += 2;
    if (bus.ra !== 16'd0) begin miscompares++; $display("FAIL rstp_late_ra got %h want 0000", bus.ra); end
    if (bus.nzp !== 3'b010) begin miscompares++; $display("FAIL rstp_late_nzp got %b want 010", bus.nzp); end
  endtask
  task automatic test_random();
    logic [15:0] d;
    for (int n = 0; n < 1000; n++) begin
      d = 16'($urandom);
      case ($urandom_range(0, 3))
        0: d = 16'd0;
        1: d[15] = 1'b1;
        default: ;
      endcase
      wb(1'($urandom_range(0, 3) != 0), 3'($urandom), d, 1'($urandom));
      bus.sr1 = 3'($urandom);
      bus.sr2 = 3'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        bus.sr1 = bus.wb_dr;
        bus.sr2 = bus.wb_dr;
      end else if ($urandom_range(0, 3) == 0) bus.sr1 = m_pdr;
      bus.br_mask = 3'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      #1;
      vectors += 5;
      if (bus.ra !== m_read(bus.sr1)) begin miscompares++; $display("FAIL rnd_ra[%0d] got %h want %h", n, bus.ra, m_read(bus.sr1)); end
      if (bus.rb !== m_read(bus.sr2)) begin miscompares++; $display("FAIL rnd_rb[%0d] got %h want %h", n, bus.rb, m_read(bus.sr2)); end
      if (bus.nzp !== m_nzp) begin miscompares++; $display("FAIL rnd_nzp[%0d] got %b want %b", n, bus.nzp, m_nzp); end
      if (bus.wb_busy !== m_pv) begin miscompares++; $display("FAIL rnd_busy[%0d] got %b want %b", n, bus.wb_busy, m_pv); end
      if (bus.br_taken !== |(bus.br_mask & m_nzp)) begin miscompares++; $display("FAIL rnd_br[%0d] got %b want %b", n, bus.br_taken, |(bus.br_mask & m_nzp)); end
      tick();
    end
    rst_n = 1'b1;
  endtask
  initial begin
    vectors     = 0;
    miscompares = 0;
    m_pv        = 1'b0;
    m_pdr       = 3'd0;
    m_pdata     = 16'd0;
    m_pcc       = 1'b0;
    m_nzp       = 3'b010;
    foreach (m_regs[i]) m_regs[i] = 16'd0;
    bus.sr1     = 3'd0;
    bus.sr2     = 3'd0;
    bus.br_mask = 3'b000;
    #2;
    test_reset();
    test_forward();
    test_back_to_back();
    test_no_cc();
    test_reset_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reg_file_cc.md
# reg_file_cc

Eight-entry, 16-bit general-purpose register file with a one-deep write-back stage and a condition-code (NZP) register. It feeds the ALU's `Ra`/`Rb` operands and consumes the ALU result, or any other write-back source, through a registered write port. Internal forwarding makes a result readable on the cycle after it is presented. The block also evaluates branch conditions against the committed NZP.

## Interface
Parameters:
- `WIDTH`, 16, data width of registers and ports.
- `AW`, 3, register address width; depth is 2^AW (8).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous reset, active-low. Sampled on the `clk` rising edge.
- `sr1`  in  AW  read address, port A.
- `sr2`  in  AW  read address, port B.
- `ra`  out  WIDTH  read data A, to ALU `Ra`; combinational from `sr1`.
- `rb`  out  WIDTH  read data B, to ALU `Rb`; combinational from `sr2`.
- `wb_valid`  in  1  write-back request, sampled each edge.
- `wb_dr`  in  AW  destination register of the write-back.
- `wb_data`  in  WIDTH  write-back value (ALU `aluOut` or memory data).
- `wb_ld_cc`  in  1  with `wb_valid`: update NZP from `wb_data` on commit.
- `br_mask`  in  3  branch condition bits {n,z,p} from the instruction.
- `br_taken`  out  1  `|(br_mask & nzp)`; combinational.
- `nzp`  out  3  committed condition codes {N,Z,P}.
- `wb_busy`  out  1  write-back stage holds an uncommitted entry.

## Operation
- State:
  - `regs[0..7]`;
  - pending stage: `p_valid`, `p_dr`, `p_data`, `p_cc`;
  - `nzp`.
- Reset (`rst_n`=0 at an edge):
  - all `regs` become 0;
  - `p_valid` becomes 0;
  - `nzp` becomes 3'b010 (Z);
  - outputs after reset: `ra`=`rb`=0, `wb_busy`=0, `nzp`=010, and `br_taken` = `br_mask[1]`.
- Reset is checked before all other logic. An entry pending at reset is discarded and never committed.
- Each non-reset edge performs two steps in parallel:
  - **Commit:** if `p_valid`, then `regs[p_dr]` ← `p_data`. If `p_cc` is also set, `nzp` ← cc(`p_data`).
  - **Capture:** `p_valid` ← `wb_valid`, and `p_dr`/`p_data`/`p_cc` ← `wb_dr`/`wb_data`/`wb_ld_cc`. When `wb_valid`=0, `p_dr`/`p_data`/`p_cc` hold their values but are ignored.
- cc(x) is one-hot:
  - N=1 when x[WIDTH-1]=1;
  - else Z=1 when x==0;
  - else P=1.
  - Exactly one bit is always set. 3'b000 or multi-hot values are illegal.
- Read forwarding:
  - `ra` = `p_data` when `p_valid` && `p_dr`==`sr1`, else `regs[sr1]`.
  - `rb` follows the same rule with `sr2`.
  - `sr1`==`sr2` is legal, and both ports return the same value.
- No stall capability. A write-back is accepted every cycle.
  - Back-to-back writes pipeline: the older entry commits on the same edge the newer one is captured.
  - Back-to-back writes to the same `dr`: the newer value wins both in forwarding and in the final register.
- `br_taken` and `nzp` use the committed NZP only; the pending `p_cc` is not forwarded. The control sequencer inserts one cycle between a cc-setting write-back and a dependent branch.
- `wb_busy` = `p_valid`.
- R0 is an ordinary writable register (not hardwired to zero).

## Timing
- Write latency: `wb_valid` sampled at edge E0.
  - Forwarded value appears on `ra`/`rb` right after E0.
  - Value lands in the array at E1.
  - `nzp` updates at E1; `br_taken` reflects the new NZP from after E1.
- Read latency: 0 cycles (combinational from address and state).
- Throughput: one write-back per cycle, sustained.

## Test plan
- Reset, then read all 8 addresses: `ra`=`rb`=0, `nzp`=010, `wb_busy`=0. With `br_mask`=010, `br_taken`=1; with 101, `br_taken`=0.
- Write R3=16'h1234 with `ld_cc`=1. Set `sr1`=3 the cycle after: `ra`=1234 (forwarded) and `wb_busy`=1. One cycle later: `ra`=1234 (from array), `nzp`=001 and `wb_busy`=0.
- Write R5=16'h8000, then R5=16'h0007 in consecutive cycles with `ld_cc`=1 both times.
  - After the first write's commit edge: `nzp`=100.
  - After the second write's commit edge: `nzp`=001 and R5=0007.
  - `rb`(`sr2`=5) shows 8000 for the first cycle and 0007 for every cycle after.
- Write R1=0 with `ld_cc`=0 while `nzp`=001: `nzp` stays 001 and R1=0. Then write R1=0 with `ld_cc`=1: `nzp`=010, and `br_mask`=010 gives `br_taken`=1.
- Capture a write of R2=16'hFFFF, then assert `rst_n`=0 on the next edge: R2 reads 0, `nzp`=010 and `wb_busy`=0. The pending entry is never committed.
- Random streams of 1000 cycles: a scoreboard model with one-cycle commit and forwarding matches `ra`, `rb` and `nzp` every cycle, including `sr1`==`sr2`==`wb_dr` collisions.
